// File: rtl/mem_bus_master_pkg.sv
// mem_bus_master_pkg: shared memory-bus state encoding and default widths/timing
package mem_bus_master_pkg;
  localparam int MEM_DWIDTH = 32;
  localparam int MEM_AWIDTH = 10;
  localparam int MEM_WAIT_CYCLES = 5;
  typedef enum logic [2:0] {IDLE, WR_REL, WR_DRV, WR_HOLD, RD_WAIT, RD_CAP, DONE} state_t;
endpackage

// File: rtl/mem_bus_master_wait_counter.sv
// bus_wait_counter: loadable 4-bit down-counter with zero flag for bus turnaround waits
module bus_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
  assign zero = cnt_q == 4'd0;
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-to-RAM bridge sequencing bus turnaround on a shared tri-state Data bus
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int DWIDTH      = MEM_DWIDTH,
  parameter int AWIDTH      = MEM_AWIDTH,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH-1:0] Addr,
  output logic              rdEn,
  output logic              wrEn,
  inout  wire  [DWIDTH-1:0] Data
);
  state_t state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rd_en_q, rd_en_d, ack_q, ack_d, busy_q, busy_d, drv_q, drv_d;
  logic accept, cnt_zero;
  assign accept = state_q == IDLE && req;
  bus_wait_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (4'(WAIT_CYCLES - 1)),
    .dec      (state_q == WR_REL || state_q == RD_WAIT),
    .zero     (cnt_zero)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req ? (we ? WR_REL : RD_WAIT) : IDLE;
      WR_REL:  state_d = cnt_zero ? WR_DRV : WR_REL;
      WR_DRV:  state_d = WR_HOLD;
      WR_HOLD: state_d = DONE;
      RD_WAIT: state_d = cnt_zero ? RD_CAP : RD_WAIT;
      RD_CAP:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    addr_d  = accept ? addr : addr_q;
    wdata_d = accept ? wdata : wdata_q;
    rdata_d = state_q == RD_CAP ? Data : rdata_q;
    // outputs are decoded from the next state so they flip together with it
    rd_en_d = state_d inside {WR_REL, WR_DRV, WR_HOLD};
    drv_d   = state_d == WR_DRV;
    ack_d   = state_d == DONE;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_en_q <= 1'b0;
      drv_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_en_q <= rd_en_d;
      drv_q   <= drv_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end
  assign Data  = drv_q ? wdata_q : 'z;
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign Addr  = addr_q;
  assign rdEn  = rd_en_q;
  assign wrEn  = rd_en_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: RAM-backed directed and random checks of mem_bus_master (WAIT 5 and WAIT 1)
module tb_mem_bus_master;
  localparam int DW = 32;
  localparam int AW = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ram_init;
  logic req_a, we_a, busy_a, ack_a, rd_en_a, wr_en_a;
  logic req_b, we_b, busy_b, ack_b, rd_en_b, wr_en_b;
  logic [AW-1:0] addr_a, maddr_a, addr_b, maddr_b;
  logic [DW-1:0] wdata_a, rdata_a, wdata_b, rdata_b;
  wire  [DW-1:0] data_a, data_b;
  logic [DW-1:0] mem_a [1000];
  logic [DW-1:0] mem_b [1000];
  logic [DW-1:0] ref_mem [1000];
  int hi_a = 0, hi_b = 0, cyc = 0, en_diff = 0;
  int checks = 0, failures = 0;

  mem_bus_master #(.DWIDTH(DW), .AWIDTH(AW), .WAIT_CYCLES(5)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .ack(ack_a), .rdata(rdata_a), .Addr(maddr_a), .rdEn(rd_en_a),
    .wrEn(wr_en_a), .Data(data_a));
  mem_bus_master #(.DWIDTH(DW), .AWIDTH(AW), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .Addr(maddr_b), .rdEn(rd_en_b),
    .wrEn(wr_en_b), .Data(data_b));

  function automatic logic [DW-1:0] init_word(int i);
    return i == 2 ? 32'h00000005 : i == 105 ? 32'h000FFFFF : ((32'(i) * 32'h01010101) ^ 32'hA5A50000);
  endfunction

  // RAM: drives Data while rdEn is low, latches the bus once the master's drive window arrives
  assign data_a = rd_en_a ? 'z : mem_a[maddr_a];
  assign data_b = rd_en_b ? 'z : mem_b[maddr_b];
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hi_a <= rd_en_a ? hi_a + 1 : 0;
    hi_b <= rd_en_b ? hi_b + 1 : 0;
    if (ram_init) begin
      for (int i = 0; i < 1000; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (rd_en_a && hi_a == 5) mem_a[maddr_a] <= data_a;
      if (rd_en_b && hi_b == 1) mem_b[maddr_b] <= data_b;
    end
  end
  always @(negedge clk) if (wr_en_a !== rd_en_a || wr_en_b !== rd_en_b) en_diff <= en_diff + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit sel, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output logic [DW-1:0] rd, output logic rd_seen);
    int t0;
    @(negedge clk);
    if (sel) begin req_b = 1; we_b = w; addr_b = a; wdata_b = d; end
    else begin req_a = 1; we_a = w; addr_a = a; wdata_a = d; end
    t0 = cyc;
    lat = -1;
    rd_seen = 0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      req_a = 0;
      req_b = 0;
      if (sel ? rd_en_b : rd_en_a) rd_seen = 1;
      if (sel ? ack_b : ack_a) lat = cyc - t0;
    end
    rd = sel ? rdata_b : rdata_a;
  endtask

  initial begin
    int lat, t0, t1, t2, n;
    logic [DW-1:0] rd, v, d;
    logic seen, w;
    logic [AW-1:0] a;
    rst = 1; ram_init = 1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    for (int i = 0; i < 1000; i++) ref_mem[i] = init_word(i);
    repeat (2) @(negedge clk);
    ram_init = 0;
    chk("rst_busy_a", busy_a, 0);   chk("rst_ack_a", ack_a, 0);
    chk("rst_rden_a", rd_en_a, 0);  chk("rst_wren_a", wr_en_a, 0);
    chk("rst_addr_a", maddr_a, 0);  chk("rst_rdata_a", rdata_a, 0);
    chk("rst_busy_b", busy_b, 0);   chk("rst_ack_b", ack_b, 0);
    chk("rst_rden_b", rd_en_b, 0);  chk("rst_wren_b", wr_en_b, 0);
    chk("rst_addr_b", maddr_b, 0);  chk("rst_rdata_b", rdata_b, 0);
    rst = 0;
    // load of a preset word
    xfer(0, 0, 10'd2, '0, lat, rd, seen);
    chk("ld2_lat", lat, 7);
    chk("ld2_rdata", rd, 32'h00000005);
    chk("ld2_rden_low", seen, 0);
    chk("ld2_addr_hold", maddr_a, 2);
    // store then load back
    xfer(0, 1, 10'd50, 32'hDEADBEEF, lat, rd, seen);
    chk("st50_lat", lat, 8);
    chk("st50_rden_high", seen, 1);
    ref_mem[50] = 32'hDEADBEEF;
    xfer(0, 0, 10'd50, '0, lat, rd, seen);
    chk("ld50_lat", lat, 7);
    chk("ld50_rdata", rd, ref_mem[50]);
    chk("ld50_no_x", $isunknown(rd), 0);
    // req held high across a store followed by a load
    v = $urandom;
    @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 10'd300; wdata_a = v;
    t0 = cyc; t1 = 0; t2 = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_a) begin
        n++;
        if (n == 1) begin t1 = cyc; we_a = 0; end
        else if (n == 2) begin t2 = cyc; req_a = 0; end
      end
    end
    req_a = 0;
    ref_mem[300] = v;
    chk("b2b_ack_count", n, 2);
    chk("b2b_store_lat", t1 - t0, 8);
    chk("b2b_load_lat", t2 - t1, 8);
    chk("b2b_rdata", rdata_a, ref_mem[300]);
    // random traffic against the reference memory
    for (int k = 0; k < 24; k++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 999));
      if (a == 10'd105) a = 10'd106;
      d = $urandom;
      xfer(0, w, a, d, lat, rd, seen);
      chk($sformatf("rnd%0d_lat", k), lat, w ? 8 : 7);
      if (w) ref_mem[a] = d;
      else chk($sformatf("rnd%0d_rdata", k), rd, ref_mem[a]);
    end
    // reset pulse during WR_REL aborts the store
    @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 10'd105; wdata_a = 32'h12345678;
    @(negedge clk);
    req_a = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack_a) n++;
    end
    chk("abort_no_ack", n, 0);
    chk("abort_idle", busy_a, 0);
    xfer(0, 0, 10'd105, '0, lat, rd, seen);
    chk("abort_ld105", rd, 32'h000FFFFF);
    // one-cycle wait states
    xfer(1, 0, 10'd105, '0, lat, rd, seen);
    chk("w1_ld105_lat", lat, 3);
    chk("w1_ld105_rdata", rd, 32'h000FFFFF);
    v = $urandom;
    xfer(1, 1, 10'd7, v, lat, rd, seen);
    chk("w1_st7_lat", lat, 4);
    xfer(1, 0, 10'd7, '0, lat, rd, seen);
    chk("w1_ld7_lat", lat, 3);
    chk("w1_ld7_rdata", rd, v);
    chk("wren_eq_rden", en_diff, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
